seg7_display_ctrl: RTL

SEG7_DISPLAY_CTRL -- requirements
Module: seg7_display_ctrl

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_display_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display controller: glyph table,
// the dark pattern and the width of one hex digit.
package seg7_pkg;

    // Width of one hex digit nibble.
    localparam int DIGIT_W = 4;

    // Raw {dp,g..a} pattern with every segment off, before polarity.
    localparam logic [7:0] SEG_DARK = 8'h00;

    // Hex glyphs in g..a order (bit 0 = segment a); b and d are lowercase.
    // Entry 15 is listed first so GLYPH_TABLE[n] selects digit n.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_decode.sv
// One digit of segment decode: nibble + dp + blank -> {dp,g..a} with the
// output polarity applied. Purely combinational; the caller registers it.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [DIGIT_W-1:0] nibble,
    input  logic               dp,
    input  logic               blank,
    output logic [7:0]         seg
);

    logic [7:0] raw;

    // Glyph lookup; a blanked digit keeps its decimal point.
    always_comb begin
        raw    = SEG_DARK;
        raw[7] = dp;
        if (!blank) begin
            raw[6:0] = GLYPH_TABLE[nibble];
        end
        seg = (ACTIVE_LOW != 0) ? ~raw : raw;
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Hex seven-segment display controller: captures a value over a valid/ready
// handshake, applies leading-zero blanking and blinking, and drives either
// static per-digit segment outputs or a time-multiplexed segment bus.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int MUX_MODE   = 0,
    parameter int ACTIVE_LOW = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DIGIT_W*DIGITS-1:0] value_in,
    input  logic                      value_valid,
    output logic                      value_ready,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic                      blank_lz,
    output logic [8*DIGITS-1:0]       seg_out,
    output logic [7:0]                seg_mux,
    output logic [DIGITS-1:0]         dig_sel
);

    localparam int                BLINK_W = $clog2(BLINK_DIV);
    localparam logic [7:0]        SEG_OFF = (ACTIVE_LOW != 0) ? ~SEG_DARK : SEG_DARK;
    localparam logic [DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Handshake: a transfer happens on any rising edge where value_valid and
    // value_ready are both high; value_ready is low for exactly the cycle
    // after a transfer and high otherwise (low while in reset).
    logic                      xfer;
    logic                      ready_d, ready_q;
    logic [DIGIT_W*DIGITS-1:0] value_d, value_q;
    logic [DIGITS-1:0]         dp_d, dp_q;
    logic [DIGITS-1:0]         mask_d, mask_q;
    logic [BLINK_W-1:0]        blink_cnt_d, blink_cnt_q;
    logic                      blink_phase_d, blink_phase_q;

    logic                      lz_run;
    logic [DIGITS-1:0]         lz_blank;
    logic [DIGITS-1:0]         dig_dark;
    logic [DIGITS-1:0]         dig_blank;
    logic [DIGITS-1:0]         dig_dp;

    assign value_ready = ready_q;

    // Capture stage and blink prescaler next-state.
    always_comb begin
        xfer          = value_valid && ready_q;
        ready_d       = !xfer;
        value_d       = value_q;
        dp_d          = dp_q;
        mask_d        = mask_q;
        if (xfer) begin
            value_d = value_in;
            dp_d    = dp_in;
            mask_d  = blink_mask;
        end
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end
    end

    // Capture and prescaler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q       <= 1'b0;
            value_q       <= '0;
            dp_q          <= '0;
            mask_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            ready_q       <= ready_d;
            value_q       <= value_d;
            dp_q          <= dp_d;
            mask_q        <= mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Per-digit blank/dp: zeros blank from the top down while every higher
    // digit is blanked; digit 0 always shows; blinking kills dp as well.
    always_comb begin
        lz_blank = '0;
        lz_run   = blank_lz;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_blank[i] = lz_run && (value_q[i*DIGIT_W +: DIGIT_W] == '0) && (i != 0);
            lz_run      = lz_blank[i];
        end
        dig_dark  = mask_q & {DIGITS{blink_phase_q}};
        dig_blank = lz_blank | dig_dark;
        dig_dp    = dp_q & ~dig_dark;
    end

    if (MUX_MODE == 0) begin : g_static
        logic [8*DIGITS-1:0] seg_out_d, seg_out_q;

        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
                .nibble (value_q[i*DIGIT_W +: DIGIT_W]),
                .dp     (dig_dp[i]),
                .blank  (dig_blank[i]),
                .seg    (seg_out_d[i*8 +: 8])
            );
        end

        // Registered decode stage for the static outputs.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) seg_out_q <= {DIGITS{SEG_OFF}};
            else          seg_out_q <= seg_out_d;
        end

        assign seg_out = seg_out_q;
        assign seg_mux = SEG_OFF;
        assign dig_sel = DIG_OFF;
    end else begin : g_mux
        localparam int SLOT_W = $clog2(SCAN_DIV);
        localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

        logic [SLOT_W-1:0]  slot_cnt_d, slot_cnt_q;
        logic [IDX_W-1:0]   idx_d, idx_q, idx_next, disp_idx;
        logic               slot_last;
        logic [DIGIT_W-1:0] mux_nib;
        logic               mux_dp, mux_blank;
        logic [DIGITS-1:0]  onehot;
        logic [7:0]         seg_mux_d, seg_mux_q;
        logic [DIGITS-1:0]  dig_sel_d, dig_sel_q;

        // Scan counters; in a slot's last cycle the selects go inactive and
        // the segment bus already carries the next digit, so no ghosting.
        always_comb begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            idx_d      = idx_q;
            if (slot_cnt_q == SLOT_W'(SCAN_DIV - 1)) begin
                slot_cnt_d = '0;
                idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            slot_last = (slot_cnt_d == SLOT_W'(SCAN_DIV - 1));
            idx_next  = (idx_d == IDX_W'(DIGITS - 1)) ? '0 : idx_d + IDX_W'(1);
            disp_idx  = slot_last ? idx_next : idx_d;
            mux_nib   = '0;
            mux_dp    = 1'b0;
            mux_blank = 1'b1;
            onehot    = '0;
            for (int i = 0; i < DIGITS; i++) begin
                if (disp_idx == IDX_W'(i)) begin
                    mux_nib   = value_q[i*DIGIT_W +: DIGIT_W];
                    mux_dp    = dig_dp[i];
                    mux_blank = dig_blank[i];
                    onehot[i] = 1'b1;
                end
            end
            dig_sel_d = slot_last ? DIG_OFF : ((ACTIVE_LOW != 0) ? ~onehot : onehot);
        end

        seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
            .nibble (mux_nib),
            .dp     (mux_dp),
            .blank  (mux_blank),
            .seg    (seg_mux_d)
        );

        // Scan counters and registered multiplexed outputs.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                slot_cnt_q <= '0;
                idx_q      <= '0;
                seg_mux_q  <= SEG_OFF;
                dig_sel_q  <= DIG_OFF;
            end else begin
                slot_cnt_q <= slot_cnt_d;
                idx_q      <= idx_d;
                seg_mux_q  <= seg_mux_d;
                dig_sel_q  <= dig_sel_d;
            end
        end

        assign seg_out = {DIGITS{SEG_OFF}};
        assign seg_mux = seg_mux_q;
        assign dig_sel = dig_sel_q;
    end

endmodule
